// File: rtl/glitch_sequencer.sv
// glitch_sequencer
//   Trigger-to-glitch timing engine. Arms on command, waits for a synchronised
//   rising edge of the raw trigger, counts a programmable delay, then emits
//   `repeat` glitch pulses of `width` cycles separated by `gap` low cycles.
//   Zero width/gap/repeat values are treated as 1.
//
// Ports
//   clk        system clock, rising edge
//   reset      synchronous active-high reset
//   i_arm      strobe: latch config and arm (IDLE only)
//   i_abort    strobe: return to IDLE from any state (wins over everything)
//   i_trig     raw asynchronous trigger
//   i_delay    cycles from trigger detect to first pulse
//   i_width    pulse high cycles
//   i_gap      low cycles between pulses
//   i_repeat   number of pulses
//   o_glitch   registered glitch output
//   o_armed    high while ARMED
//   o_waiting  high while in DELAY or GAP
//   o_firing   high while in PULSE
//   o_done     one-cycle strobe when a sequence completes (not on abort)
//
// Configuration
//   TRIG_FILTER_EN  when defined, a trigger edge is accepted only if the
//                   synchronised trigger stays high FILT_LEN further cycles.

module glitch_sequencer #(
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned REP_W    = 8,
  parameter int unsigned FILT_LEN = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_arm,
  input  logic             i_abort,
  input  logic             i_trig,
  input  logic [CNT_W-1:0] i_delay,
  input  logic [CNT_W-1:0] i_width,
  input  logic [CNT_W-1:0] i_gap,
  input  logic [REP_W-1:0] i_repeat,
  output logic             o_glitch,
  output logic             o_armed,
  output logic             o_waiting,
  output logic             o_firing,
  output logic             o_done
);

  typedef enum logic [2:0] {
    StIdle, StArmed, StDelay, StPulse, StGap, StDone
  } state_e;

  state_e state_q;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] delay_q, width_q, gap_q;
  logic [REP_W-1:0] rep_q;

  // Two-flop synchroniser plus a third flop for edge detection.
  logic s1_q, s2_q, s3_q;
  logic trig_ev_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= i_trig;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

`ifdef TRIG_FILTER_EN
  localparam int unsigned RunW = $clog2(FILT_LEN + 1);
  logic [RunW-1:0] run_q;

  // run_q counts how long s2 has stayed high since an edge seen while ARMED;
  // any drop before FILT_LEN further cycles discards the edge as a runt.
  always_ff @(posedge clk) begin
    if (reset || state_q != StArmed) begin
      run_q     <= '0;
      trig_ev_q <= 1'b0;
    end else begin
      trig_ev_q <= 1'b0;
      if (run_q == '0) begin
        if (s2_q && !s3_q) run_q <= RunW'(1);
      end else if (!s2_q) begin
        run_q <= '0;
      end else if (run_q == RunW'(FILT_LEN)) begin
        trig_ev_q <= 1'b1;
        run_q     <= '0;
      end else begin
        run_q <= run_q + RunW'(1);
      end
    end
  end
`else
  // Only edges observed while ARMED count; a level already high at arm time
  // produces no edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      trig_ev_q <= 1'b0;
    end else begin
      trig_ev_q <= (state_q == StArmed) && s2_q && !s3_q;
    end
  end
`endif

  // Counter is reloaded with 1 on every state entry and counts up to the
  // latched terminal value, so a state lasts exactly that many cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      delay_q   <= '0;
      width_q   <= '0;
      gap_q     <= '0;
      rep_q     <= '0;
      o_glitch  <= 1'b0;
      o_armed   <= 1'b0;
      o_waiting <= 1'b0;
      o_firing  <= 1'b0;
      o_done    <= 1'b0;
    end else begin
      o_done <= 1'b0;
      if (i_abort) begin
        state_q   <= StIdle;
        o_glitch  <= 1'b0;
        o_armed   <= 1'b0;
        o_waiting <= 1'b0;
        o_firing  <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (i_arm) begin
              delay_q <= i_delay;
              width_q <= (i_width == '0) ? CNT_W'(1) : i_width;
              gap_q   <= (i_gap == '0) ? CNT_W'(1) : i_gap;
              rep_q   <= (i_repeat == '0) ? REP_W'(1) : i_repeat;
              state_q <= StArmed;
              o_armed <= 1'b1;
            end
          end
          StArmed: begin
            if (trig_ev_q) begin
              cnt_q   <= CNT_W'(1);
              o_armed <= 1'b0;
              if (delay_q == '0) begin
                state_q  <= StPulse;
                o_firing <= 1'b1;
                o_glitch <= 1'b1;
              end else begin
                state_q   <= StDelay;
                o_waiting <= 1'b1;
              end
            end
          end
          StDelay, StGap: begin
            if (cnt_q == ((state_q == StDelay) ? delay_q : gap_q)) begin
              state_q   <= StPulse;
              cnt_q     <= CNT_W'(1);
              o_waiting <= 1'b0;
              o_firing  <= 1'b1;
              o_glitch  <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          StPulse: begin
            if (cnt_q == width_q) begin
              cnt_q    <= CNT_W'(1);
              rep_q    <= rep_q - REP_W'(1);
              o_firing <= 1'b0;
              o_glitch <= 1'b0;
              if (rep_q == REP_W'(1)) begin
                state_q <= StDone;
              end else begin
                state_q   <= StGap;
                o_waiting <= 1'b1;
              end
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          StDone: begin
            state_q <= StIdle;
            o_done  <= 1'b1;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule
